// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/write-back stage: opcodes, FSM states,
// instruction field positions and opcode legality.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'h00;
    localparam logic [5:0] OP_SUB = 6'h01;
    localparam logic [5:0] OP_MUL = 6'h02;
    localparam logic [5:0] OP_DIV = 6'h03;
    localparam logic [5:0] OP_CMP = 6'h04;
    localparam logic [5:0] OP_NOT = 6'h08;
    localparam logic [5:0] OP_AND = 6'h09;
    localparam logic [5:0] OP_OR  = 6'h0A;
    localparam logic [5:0] OP_XOR = 6'h0B;

    localparam int unsigned OP_MSB  = 15;
    localparam int unsigned OP_LSB  = 10;
    localparam int unsigned RD_MSB  = 9;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned RS1_MSB = 6;
    localparam int unsigned RS1_LSB = 4;
    localparam int unsigned RS2_MSB = 3;
    localparam int unsigned RS2_LSB = 1;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP,
            OP_NOT, OP_AND, OP_OR, OP_XOR: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_stage_regfile.sv
// Register file: one synchronous write port, three combinational read ports.
module alu_regfile #(
    parameter int unsigned REGS = 8,
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    input  logic [AW-1:0] raddr_b_i,
    input  logic [AW-1:0] raddr_dbg_i,
    output logic [DW-1:0] rdata_a_o,
    output logic [DW-1:0] rdata_b_o,
    output logic [DW-1:0] rdata_dbg_o
);

    logic [DW-1:0] rf_q [REGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
        end else if (we_i) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o   = rf_q[raddr_a_i];
    assign rdata_b_o   = rf_q[raddr_b_i];
    assign rdata_dbg_o = rf_q[raddr_dbg_i];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/write-back stage for the 8-bit ALU: one instruction in flight, operands
// registered at accept, result written back at the end of EXEC.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned REGS = 8,
    parameter int unsigned DW   = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          instr_valid_i,
    output logic          instr_ready_o,
    input  logic [15:0]   instr_i,
    input  logic          ld_en_i,
    input  logic [2:0]    ld_addr_i,
    input  logic [DW-1:0] ld_data_i,
    output logic [DW-1:0] alu_a_o,
    output logic [DW-1:0] alu_b_o,
    output logic [5:0]    alu_op_o,
    input  logic [15:0]   alu_result_i,
    output logic          wb_valid_o,
    output logic [2:0]    wb_rd_o,
    output logic [DW-1:0] wb_data_o,
    output logic          zero_flag_o,
    output logic          div_err_o,
    input  logic [2:0]    dbg_addr_i,
    output logic [DW-1:0] dbg_data_o
);

    state_e        state_q;
    logic [DW-1:0] alu_a_q, alu_b_q;
    logic [5:0]    alu_op_q;
    logic [2:0]    rd_q;
    logic          wb_valid_q, zero_q, div_err_q;
    logic [2:0]    wb_rd_q;
    logic [DW-1:0] wb_data_q;

    logic [DW-1:0] rs1_data, rs2_data;
    logic          legal, div_zero, wb_fire;
    logic [DW-1:0] res_d;
    logic          rf_we;
    logic [2:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;

    logic unused_bits;
    assign unused_bits = ^{alu_result_i[15:DW], instr_i[0]};

    always_comb begin
        legal    = is_legal_op(alu_op_q);
        div_zero = (alu_op_q == OP_DIV) && (alu_b_q == '0);
        res_d    = alu_result_i[DW-1:0];
        if (alu_op_q == OP_CMP) res_d = {{(DW-2){1'b0}}, alu_result_i[1:0]};
        if (div_zero)           res_d = '1;
    end

    // Loads and write-backs never collide: loads only land in IDLE.
    assign wb_fire  = (state_q == EXEC) && legal;
    assign rf_we    = wb_fire || ((state_q == IDLE) && ld_en_i);
    assign rf_waddr = wb_fire ? rd_q  : ld_addr_i;
    assign rf_wdata = wb_fire ? res_d : ld_data_i;

    alu_regfile #(
        .REGS (REGS),
        .DW   (DW),
        .AW   (3)
    ) u_regfile (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .we_i        (rf_we),
        .waddr_i     (rf_waddr),
        .wdata_i     (rf_wdata),
        .raddr_a_i   (instr_i[RS1_MSB:RS1_LSB]),
        .raddr_b_i   (instr_i[RS2_MSB:RS2_LSB]),
        .raddr_dbg_i (dbg_addr_i),
        .rdata_a_o   (rs1_data),
        .rdata_b_o   (rs2_data),
        .rdata_dbg_o (dbg_data_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            zero_q     <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (instr_valid_i) begin
                        alu_a_q  <= rs1_data;
                        alu_b_q  <= rs2_data;
                        alu_op_q <= instr_i[OP_MSB:OP_LSB];
                        rd_q     <= instr_i[RD_MSB:RD_LSB];
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    if (legal) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= res_d;
                        zero_q     <= (res_d == '0);
                        if (div_zero) div_err_q <= 1'b1;
                    end
                    state_q <= WB;
                end
                WB:      state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_ready_o = (state_q == IDLE);
    assign alu_a_o       = alu_a_q;
    assign alu_b_o       = alu_b_q;
    assign alu_op_o      = alu_op_q;
    assign wb_valid_o    = wb_valid_q;
    assign wb_rd_o       = wb_rd_q;
    assign wb_data_o     = wb_data_q;
    assign zero_flag_o   = zero_q;
    assign div_err_o     = div_err_q;

endmodule
